// File: rtl/axi_lite_arbiter_2to1_pkg.sv
// Shared constants for the IFU/LSU AXI4-Lite arbiter: response codes,
// FSM state encodings and a small one-hot helper.
package axi_lite_arbiter_2to1_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_RD = 2'd1;
    localparam logic [1:0] ST_BUSY_WR = 2'd2;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_lite_arbiter_2to1_rr_arb2.sv
// Two-request picker: a lone requester always wins; on a tie the master that
// did not own the bus last wins (round-robin) or the fixed-priority master wins.
module rr_arb2
    import axi_lite_arbiter_2to1_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_en ? onehot2(~last) : onehot2(prio);
        end
    end

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Shares one AXI4-Lite master port between IFU (master 0) and LSU (master 1),
// granting whole transactions (AR..R or AW+W..B) with one outstanding in total.
module axi_lite_arbiter_2to1
    import axi_lite_arbiter_2to1_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1,
    parameter bit PRIO_M = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*ADDR_W-1:0]     m_awaddr,
    input  logic [1:0]              m_awvalid,
    output logic [1:0]              m_awready,
    input  logic [2*DATA_W-1:0]     m_wdata,
    input  logic [2*DATA_W/8-1:0]   m_wstrb,
    input  logic [1:0]              m_wvalid,
    output logic [1:0]              m_wready,
    output logic [3:0]              m_bresp,
    output logic [1:0]              m_bvalid,
    input  logic [1:0]              m_bready,
    input  logic [2*ADDR_W-1:0]     m_araddr,
    input  logic [1:0]              m_arvalid,
    output logic [1:0]              m_arready,
    output logic [2*DATA_W-1:0]     m_rdata,
    output logic [3:0]              m_rresp,
    output logic [1:0]              m_rvalid,
    input  logic [1:0]              m_rready,
    output logic [ADDR_W-1:0]       s_awaddr,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_W-1:0]       s_wdata,
    output logic [DATA_W/8-1:0]     s_wstrb,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic [ADDR_W-1:0]       s_araddr,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [DATA_W-1:0]       s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic [1:0]              grant,
    output logic                    busy
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              ar_done_q, ar_done_d;

    logic [1:0]        req, arb_gnt;
    logic              rd_act, wr_act, ar_fwd, aw_fwd, w_fwd;
    logic [ADDR_W-1:0] own_araddr, own_awaddr;
    logic [DATA_W-1:0] own_wdata;
    logic [STRB_W-1:0] own_wstrb;

    // A master that raises both AW and AR is treated as a write request.
    assign req    = m_awvalid | m_arvalid;
    assign rd_act = (state_q == ST_BUSY_RD);
    assign wr_act = (state_q == ST_BUSY_WR);
    assign ar_fwd = rd_act & ~ar_done_q;
    assign aw_fwd = wr_act & ~aw_done_q;
    assign w_fwd  = wr_act & ~w_done_q;

    assign own_araddr = owner_q ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
    assign own_awaddr = owner_q ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    assign own_wdata  = owner_q ? m_wdata[2*DATA_W-1:DATA_W]  : m_wdata[DATA_W-1:0];
    assign own_wstrb  = owner_q ? m_wstrb[2*STRB_W-1:STRB_W]  : m_wstrb[STRB_W-1:0];

    rr_arb2 u_arb (
        .req   (req),
        .last  (last_owner_q),
        .rr_en (RR_EN),
        .prio  (PRIO_M),
        .gnt   (arb_gnt)
    );

    // Done flags block a second beat on a channel that already handshook.
    assign s_arvalid = ar_fwd & m_arvalid[owner_q];
    assign s_araddr  = ar_fwd ? own_araddr : '0;
    assign s_rready  = rd_act & m_rready[owner_q];
    assign s_awvalid = aw_fwd & m_awvalid[owner_q];
    assign s_awaddr  = aw_fwd ? own_awaddr : '0;
    assign s_wvalid  = w_fwd & m_wvalid[owner_q];
    assign s_wdata   = w_fwd ? own_wdata : '0;
    assign s_wstrb   = w_fwd ? own_wstrb : '0;
    assign s_bready  = wr_act & aw_done_q & w_done_q & m_bready[owner_q];

    assign busy  = (state_q != ST_IDLE);
    assign grant = busy ? onehot2(owner_q) : 2'b00;

    // NOTE: every output gets a default before the routing below so no latch is inferred.
    always_comb begin
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        m_rdata   = '0;
        m_rresp   = 4'b0;
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        m_bresp   = 4'b0;
        if (rd_act) begin
            m_arready[owner_q] = s_arready & ~ar_done_q;
            m_rvalid[owner_q]  = s_rvalid;
            if (owner_q) begin
                m_rdata[2*DATA_W-1:DATA_W] = s_rdata;
                m_rresp[3:2]               = s_rresp;
            end else begin
                m_rdata[DATA_W-1:0] = s_rdata;
                m_rresp[1:0]        = s_rresp;
            end
        end
        if (wr_act) begin
            m_awready[owner_q] = s_awready & ~aw_done_q;
            m_wready[owner_q]  = s_wready & ~w_done_q;
            m_bvalid[owner_q]  = s_bvalid;
            if (owner_q) m_bresp[3:2] = s_bresp;
            else         m_bresp[1:0] = s_bresp;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        ar_done_d    = ar_done_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = arb_gnt[1];
                    state_d = m_awvalid[arb_gnt[1]] ? ST_BUSY_WR : ST_BUSY_RD;
                end
            end
            ST_BUSY_RD: begin
                if (s_arvalid & s_arready) ar_done_d = 1'b1;
                if (s_rvalid & s_rready) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    ar_done_d    = 1'b0;
                end
            end
            ST_BUSY_WR: begin
                if (s_awvalid & s_awready) aw_done_d = 1'b1;
                if (s_wvalid & s_wready)   w_done_d  = 1'b1;
                if (s_bvalid & s_bready) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            ar_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            ar_done_q    <= ar_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for axi_lite_arbiter_2to1: two master models, a slave model and a
// scoreboard of expected completions, plus a fixed-priority instance.
module tb_axi_lite_arbiter_2to1;
    import axi_lite_arbiter_2to1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // round-robin instance
    logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [7:0]  m_wstrb;
    logic [3:0]  m_bresp, m_rresp;
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, grant;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, busy;

    // fixed-priority instance (reads only)
    logic [1:0]  p_m_arvalid, p_m_awready, p_m_wready, p_m_bvalid, p_m_arready, p_m_rvalid, p_grant;
    logic [3:0]  p_m_bresp, p_m_rresp;
    logic [63:0] p_m_rdata;
    logic [31:0] p_s_awaddr, p_s_wdata, p_s_araddr, p_s_rdata;
    logic [3:0]  p_s_wstrb;
    logic        p_s_awvalid, p_s_wvalid, p_s_bready, p_s_arvalid, p_s_arready;
    logic        p_s_rvalid, p_s_rready, p_busy;

    axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1), .PRIO_M(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0), .PRIO_M(1'b1)) dut_prio (
        .clk(clk), .rst(rst),
        .m_awaddr(64'h0), .m_awvalid(2'b00), .m_awready(p_m_awready),
        .m_wdata(64'h0), .m_wstrb(8'h0), .m_wvalid(2'b00), .m_wready(p_m_wready),
        .m_bresp(p_m_bresp), .m_bvalid(p_m_bvalid), .m_bready(2'b11),
        .m_araddr(64'h2200_0004_1100_0000), .m_arvalid(p_m_arvalid), .m_arready(p_m_arready),
        .m_rdata(p_m_rdata), .m_rresp(p_m_rresp), .m_rvalid(p_m_rvalid), .m_rready(2'b11),
        .s_awaddr(p_s_awaddr), .s_awvalid(p_s_awvalid), .s_awready(1'b0),
        .s_wdata(p_s_wdata), .s_wstrb(p_s_wstrb), .s_wvalid(p_s_wvalid), .s_wready(1'b0),
        .s_bresp(2'b00), .s_bvalid(1'b0), .s_bready(p_s_bready),
        .s_araddr(p_s_araddr), .s_arvalid(p_s_arvalid), .s_arready(p_s_arready),
        .s_rdata(p_s_rdata), .s_rresp(RESP_OKAY), .s_rvalid(p_s_rvalid), .s_rready(p_s_rready),
        .grant(p_grant), .busy(p_busy)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } txn_t;
    typedef struct { int mst; txn_t t; } exp_t;

    txn_t mq[2][$];
    exp_t sb[$];
    bit   m_act[2];
    int   n_checks = 0, n_errors = 0, cyc = 0;
    int   r0_hs_cyc = -1, first_aw_cyc = -1, aw_hs_cyc = -1, w_hs_cyc = -1, p_cnt = 0;
    int   aw_stall = 0;
    bit   ar_hold = 1'b0;
    logic        sl_aw_got, sl_w_got;
    logic [31:0] sl_awaddr, sl_wdata;
    logic [3:0]  sl_wstrb;
    logic [1:0]  h_m_ar, h_m_aw, h_m_w, h_m_r, h_m_b;
    logic        h_s_ar, h_s_aw, h_s_w, h_s_r, h_s_b, h_s_awv, h_p_ar, h_p_r;
    logic [31:0] h_araddr, h_awaddr, h_wdata;
    logic [3:0]  h_wstrb;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h3000_0000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[2] ? RESP_SLVERR : (a[3] ? RESP_DECERR : RESP_OKAY);
    endfunction

    task automatic check(input string tag, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act_v, exp_v, cyc);
        end
    endtask

    task automatic issue(input int mst, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
        mq[mst].push_back(t);
    endtask

    task automatic expect_txn(input int mst, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        e.mst = mst; e.t.wr = wr; e.t.addr = addr; e.t.data = data; e.t.strb = strb;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (m_rvalid[i] && m_rready[i]) begin
                if (i == 0) r0_hs_cyc = cyc;
                check("r_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("r_master", i, e.mst);
                    check("r_data", m_rdata[i*32 +: 32], rd_val(e.t.addr));
                    check("r_resp", m_rresp[i*2 +: 2], resp_of(e.t.addr));
                end
            end
            if (m_bvalid[i] && m_bready[i]) begin
                check("b_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b_master", i, e.mst);
                    check("b_resp", m_bresp[i*2 +: 2], resp_of(e.t.addr));
                    check("b_awaddr", sl_awaddr, e.t.addr);
                    check("b_wdata", sl_wdata, e.t.data);
                    check("b_wstrb", sl_wstrb, e.t.strb);
                end
            end
        end
        if ((m_rvalid | m_bvalid) != 2'b00)
            check("resp_to_owner_only", (m_rvalid | m_bvalid) & ~grant, 2'b00);
        if (s_awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
        if (h_s_aw && aw_hs_cyc < 0) aw_hs_cyc = cyc;
        if (h_s_w && w_hs_cyc < 0) w_hs_cyc = cyc;
        if (p_grant != 2'b00) check("prio_grant", p_grant, 2'b10);
        if (p_m_rvalid != 2'b00) check("prio_rvalid", p_m_rvalid, 2'b10);
        if (p_m_rvalid[1]) p_cnt++;
    endtask

    task automatic reset_model();
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
        m_araddr = '0; m_arvalid = '0; m_rready = '0; m_bready = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        p_s_arready = 0; p_s_rvalid = 0; p_s_rdata = '0;
        m_act[0] = 0; m_act[1] = 0;
        sl_aw_got = 0; sl_w_got = 0; sl_awaddr = '0; sl_wdata = '0; sl_wstrb = '0;
    endtask

    task automatic step_model();
        txn_t t;
        if (h_s_r) s_rvalid = 0;
        if (h_s_ar) begin
            s_rvalid = 1; s_rdata = rd_val(h_araddr); s_rresp = resp_of(h_araddr);
        end
        s_arready = !ar_hold;
        if (h_s_b) begin s_bvalid = 0; sl_aw_got = 0; sl_w_got = 0; end
        if (h_s_aw) begin sl_aw_got = 1; sl_awaddr = h_awaddr; end
        if (h_s_w) begin sl_w_got = 1; sl_wdata = h_wdata; sl_wstrb = h_wstrb; end
        if (sl_aw_got && sl_w_got && !s_bvalid) begin s_bvalid = 1; s_bresp = resp_of(sl_awaddr); end
        if (h_s_awv && aw_stall > 0) aw_stall--;
        s_awready = (aw_stall == 0);
        s_wready  = 1;
        m_rready  = 2'b11;
        m_bready  = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
                if (h_m_ar[i]) m_arvalid[i] = 0;
                if (h_m_aw[i]) m_awvalid[i] = 0;
                if (h_m_w[i])  m_wvalid[i]  = 0;
                if (h_m_r[i] || h_m_b[i]) m_act[i] = 0;
            end
            if (!m_act[i] && mq[i].size() > 0) begin
                t = mq[i].pop_front();
                m_act[i] = 1;
                if (t.wr) begin
                    m_awaddr[i*32 +: 32] = t.addr; m_awvalid[i] = 1;
                    m_wdata[i*32 +: 32] = t.data; m_wstrb[i*4 +: 4] = t.strb; m_wvalid[i] = 1;
                end else begin
                    m_araddr[i*32 +: 32] = t.addr; m_arvalid[i] = 1;
                end
            end
        end
        if (h_p_r) p_s_rvalid = 0;
        if (h_p_ar) begin p_s_rvalid = 1; p_s_rdata = 32'h100 + cyc; end
        p_s_arready = 1;
    endtask

    // Handshakes are sampled at the falling edge; model outputs move just after the rising edge.
    initial begin : bfm
        forever begin
            @(negedge clk);
            h_m_ar = m_arvalid & m_arready; h_m_aw = m_awvalid & m_awready;
            h_m_w  = m_wvalid & m_wready;   h_m_r  = m_rvalid & m_rready;
            h_m_b  = m_bvalid & m_bready;
            h_s_ar = s_arvalid & s_arready; h_s_aw = s_awvalid & s_awready;
            h_s_w  = s_wvalid & s_wready;   h_s_r  = s_rvalid & s_rready;
            h_s_b  = s_bvalid & s_bready;   h_s_awv = s_awvalid;
            h_araddr = s_araddr; h_awaddr = s_awaddr; h_wdata = s_wdata; h_wstrb = s_wstrb;
            h_p_ar = p_s_arvalid & p_s_arready; h_p_r = p_s_rvalid & p_s_rready;
            if (rst) monitor();
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) reset_model();
            else step_model();
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while ((sb.size() != 0 || mq[0].size() != 0 || mq[1].size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_completed_in_time"}, n < 300, 1);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : tests
        int n;
        reset_model();
        p_m_arvalid = 2'b00;
        #1 rst = 0;
        #2;
        check("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid}, 3'b000);
        check("rst_s_readies", {s_rready, s_bready}, 2'b00);
        check("rst_m_readies", {m_arready, m_awready, m_wready}, 6'b0);
        check("rst_m_valids", {m_rvalid, m_bvalid}, 4'b0);
        check("rst_grant_busy", {grant, busy}, 3'b000);
        check("rst_data", {s_araddr, s_awaddr}, 64'h0);
        check("rst_wdata_rdata", {s_wdata, m_rdata[31:0]}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1;

        // IFU read alone
        @(negedge clk);
        issue(0, 0, 32'h3000_0000, 0, 4'h0);
        expect_txn(0, 0, 32'h3000_0000, 0, 4'h0);
        @(negedge clk);
        check("t1_arvalid_in", m_arvalid, 2'b01);
        check("t1_no_fwd_in_idle", s_arvalid, 0);
        @(negedge clk);
        check("t1_s_arvalid", s_arvalid, 1);
        check("t1_s_araddr", s_araddr, 32'h3000_0000);
        check("t1_grant", grant, 2'b01);
        wait_done("t1");

        // Simultaneous IFU read and LSU write after reset: IFU first
        apply_reset();
        r0_hs_cyc = -1; first_aw_cyc = -1;
        issue(0, 0, 32'h1000_0040, 0, 4'h0);
        issue(1, 1, 32'h8000_0004, 32'h1234_5678, 4'hF);
        expect_txn(0, 0, 32'h1000_0040, 0, 4'h0);
        expect_txn(1, 1, 32'h8000_0004, 32'h1234_5678, 4'hF);
        wait_done("t2");
        // one IDLE cycle separates the R handshake from the write being forwarded
        check("t2_aw_after_r", first_aw_cyc, r0_hs_cyc + 2);

        // Four back-to-back reads from each master, alternating grants
        for (int k = 0; k < 4; k++) begin
            issue(0, 0, 32'h2000_0000 + 32'(k * 4), 0, 4'h0);
            issue(1, 0, 32'h2100_0000 + 32'(k * 4), 0, 4'h0);
        end
        for (int k = 0; k < 4; k++) begin
            expect_txn(0, 0, 32'h2000_0000 + 32'(k * 4), 0, 4'h0);
            expect_txn(1, 0, 32'h2100_0000 + 32'(k * 4), 0, 4'h0);
        end
        wait_done("t3");

        // AW stalled three cycles, W accepted at once
        aw_hs_cyc = -1; w_hs_cyc = -1;
        aw_stall = 3;
        issue(1, 1, 32'h4000_0008, 32'hCAFE_F00D, 4'h5);
        expect_txn(1, 1, 32'h4000_0008, 32'hCAFE_F00D, 4'h5);
        repeat (8) begin
            @(negedge clk);
            if (!sl_aw_got) check("t4_bready_low_before_aw", s_bready, 0);
        end
        wait_done("t4");
        check("t4_w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
        check("t4_aw_stall_len", aw_hs_cyc - w_hs_cyc, 3);

        // Asynchronous reset during BUSY_RD with AR pending
        ar_hold = 1;
        issue(0, 0, 32'h5000_0010, 0, 4'h0);
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        check("t5_busy", busy, 1);
        check("t5_ar_pending", s_arvalid, 1);
        #2 rst = 0;
        #1;
        check("t5_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 5'b0);
        check("t5_m_sigs", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 10'b0);
        check("t5_grant_busy", {grant, busy}, 3'b000);
        mq[0].delete(); mq[1].delete(); sb.delete();
        ar_hold = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        issue(1, 0, 32'h6000_0014, 0, 4'h0);
        expect_txn(1, 0, 32'h6000_0014, 0, 4'h0);
        wait_done("t5");

        // Fixed priority instance, both masters requesting continuously
        p_cnt = 0;
        p_m_arvalid = 2'b11;
        repeat (40) @(negedge clk);
        check("t6_progress", p_cnt >= 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
